// File: rtl/alu_pkg.sv
// Shared ALU control encodings, opcode constants and PSR bit positions
// for the execute-stage datapath.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_XOR  = 3'b010,
    ALU_ADD  = 3'b011,
    ALU_SUB  = 3'b100,
    ALU_PASS = 3'b111
  } alucont_e;

  // Opcode 0000 defers the operation choice to opext
  localparam logic [3:0] OP_EXT = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1011;

  localparam int PSR_C = 0;
  localparam int PSR_F = 1;
  localparam int PSR_L = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;

endpackage

// File: rtl/alu.sv
// Combinational ALU producing a result and the processor status flags.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucont,
  output logic [WIDTH-1:0] result,
  output logic [5:0]       psr
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  alucont_e       op;

  always_comb begin
    op     = alucont_e'(alucont);
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    psr    = '0;
    unique case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_ADD: begin
        result     = sum[WIDTH-1:0];
        psr[PSR_C] = sum[WIDTH];
        psr[PSR_F] = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        // The 17th bit of the widened difference is the unsigned borrow
        result     = diff[WIDTH-1:0];
        psr[PSR_C] = diff[WIDTH];
        psr[PSR_L] = (b < a);
        psr[PSR_F] = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      default: result = b;
    endcase
    if (op != ALU_PASS) begin
      psr[PSR_Z] = (result == '0);
      psr[PSR_N] = result[WIDTH-1];
    end
  end

endmodule

// File: rtl/alucontrol.sv
// Maps opcode/opext onto the ALU control encoding.
module alucontrol
  import alu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] opext,
  output logic [2:0] alucont
);

  logic [3:0] sel;

  always_comb begin
    sel = (opcode == OP_EXT) ? opext : opcode;
    unique case (sel)
      OP_AND:         alucont = ALU_AND;
      OP_OR:          alucont = ALU_OR;
      OP_XOR:         alucont = ALU_XOR;
      OP_ADD:         alucont = ALU_ADD;
      OP_SUB, OP_CMP: alucont = ALU_SUB;
      default:        alucont = ALU_PASS;
    endcase
  end

endmodule

// File: rtl/regfile.sv
// General-purpose register file: two combinational read ports and one
// write port that updates on the rising clock edge.
module regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             regwrite,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
);

  logic [NREGS-1:0][WIDTH-1:0] regs_q;
  logic [NREGS-1:0][WIDTH-1:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (regwrite) begin
      regs_d[wa] = wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads come straight from the flops, so a same-cycle write is not bypassed
  assign rd1 = regs_q[ra1];
  assign rd2 = regs_q[ra2];

endmodule

// File: rtl/alu_regfile_datapath.sv
// Execute-stage slice: register file feeding a decoded combinational ALU.
module alu_regfile_datapath #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             regwrite,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic [3:0]       opcode,
  input  logic [3:0]       opext,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] result,
  output logic [5:0]       psr
);

  logic [2:0] alucont;

  regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .regwrite (regwrite),
    .wa       (wa),
    .wd       (wd),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2)
  );

  alucontrol u_alucontrol (
    .opcode  (opcode),
    .opext   (opext),
    .alucont (alucont)
  );

  alu #(.WIDTH(WIDTH)) u_alu (
    .a       (rd1),
    .b       (rd2),
    .alucont (alucont),
    .result  (result),
    .psr     (psr)
  );

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Self-checking bench: directed datapath cases followed by random register
// writes and ALU operations compared against an arithmetic reference model.
module tb_alu_regfile_datapath;

  logic        clk;
  logic        rst_n;
  logic        regwrite;
  logic [3:0]  wa;
  logic [15:0] wd;
  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic [3:0]  opcode;
  logic [3:0]  opext;
  logic [15:0] rd1;
  logic [15:0] rd2;
  logic [15:0] result;
  logic [5:0]  psr;

  logic [15:0] model [16];
  int          errors = 0;
  int          checks = 0;

  alu_regfile_datapath dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .regwrite (regwrite),
    .wa       (wa),
    .wd       (wd),
    .ra1      (ra1),
    .ra2      (ra2),
    .opcode   (opcode),
    .opext    (opext),
    .rd1      (rd1),
    .rd2      (rd2),
    .result   (result),
    .psr      (psr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU built from integer arithmetic; returns {psr, result}
  function automatic logic [21:0] refAlu(input logic [3:0] opc, input logic [3:0] opx,
                                         input logic [15:0] a, input logic [15:0] b);
    logic [3:0]  s;
    logic [15:0] r;
    logic        n, z, l, f, c;
    int          ua, ub, sa, sb, t;
    s  = (opc == 4'd0) ? opx : opc;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = b; l = 0; f = 0; c = 0;
    case (s)
      4'd1: r = a & b;
      4'd2: r = a | b;
      4'd3: r = a ^ b;
      4'd5: begin
        t = ua + ub;
        r = t[15:0];
        c = (t > 65535);
        f = ((sa + sb) > 32767) || ((sa + sb) < -32768);
      end
      4'd9, 4'd11: begin
        t = ua - ub;
        r = t[15:0];
        c = (ua < ub);
        l = (ub < ua);
        f = ((sa - sb) > 32767) || ((sa - sb) < -32768);
      end
      default: return {6'b000000, b};
    endcase
    n = r[15];
    z = (r == 16'h0000);
    return {1'b0, n, z, l, f, c, r};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] a1, input logic [3:0] a2,
                               input logic [3:0] opc, input logic [3:0] opx);
    @(negedge clk);
    ra1    = a1;
    ra2    = a2;
    opcode = opc;
    opext  = opx;
    #1;
  endtask

  task automatic writeReg(input logic [3:0] addr, input logic [15:0] data);
    @(negedge clk);
    regwrite = 1'b1;
    wa       = addr;
    wd       = data;
    @(posedge clk);
    #1;
    regwrite    = 1'b0;
    model[addr] = data;
  endtask

  task automatic checkModel(input string tag);
    logic [21:0] exp;
    exp = refAlu(opcode, opext, model[ra1], model[ra2]);
    checkOutput({tag, ".rd1"}, 32'(rd1), 32'(model[ra1]));
    checkOutput({tag, ".rd2"}, 32'(rd2), 32'(model[ra2]));
    checkOutput({tag, ".result"}, 32'(result), 32'(exp[15:0]));
    checkOutput({tag, ".psr"}, 32'(psr), 32'(exp[21:16]));
  endtask

  initial begin
    logic [15:0] corner [5];
    logic [15:0] d;
    corner = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    rst_n = 1'b0; regwrite = 1'b0; wa = 4'd0; wd = 16'h0000;
    ra1 = 4'd0; ra2 = 4'd1; opcode = 4'b0101; opext = 4'd0;

    // Reset state
    applyStimulus(4'd0, 4'd1, 4'b0101, 4'd0);
    checkOutput("reset.rd1", 32'(rd1), 32'h0);
    checkOutput("reset.rd2", 32'(rd2), 32'h0);
    checkOutput("reset.result", 32'(result), 32'h0);
    checkOutput("reset.psr_add", 32'(psr), 32'h08);
    applyStimulus(4'd0, 4'd0, 4'b0111, 4'd0);
    checkOutput("reset.psr_pass", 32'(psr), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Write, read back, then asynchronous reset clears without a clock edge
    writeReg(4'd3, 16'h000A);
    writeReg(4'd2, 16'h000A);
    applyStimulus(4'd3, 4'd2, 4'b0111, 4'd0);
    checkOutput("rf.rd1", 32'(rd1), 32'h000A);
    checkOutput("rf.rd2", 32'(rd2), 32'h000A);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst.rd1", 32'(rd1), 32'h0);
    checkOutput("async_rst.rd2", 32'(rd2), 32'h0);
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    #1;
    rst_n = 1'b1;

    // Logic ops
    writeReg(4'd1, 16'h0F0F);
    writeReg(4'd2, 16'h5FBD);
    applyStimulus(4'd1, 4'd2, 4'b0001, 4'd0); checkOutput("and", 32'(result), 32'h0F0D);
    applyStimulus(4'd1, 4'd2, 4'b0010, 4'd0); checkOutput("or", 32'(result), 32'h5FBF);
    applyStimulus(4'd1, 4'd2, 4'b0011, 4'd0); checkOutput("xor", 32'(result), 32'h50B2);
    applyStimulus(4'd1, 4'd2, 4'b0000, 4'b0010); checkOutput("ext_or", 32'(result), 32'h5FBF);

    // ADD
    writeReg(4'd4, 16'hFFFF); writeReg(4'd5, 16'hFFFF);
    writeReg(4'd6, 16'h0001); writeReg(4'd7, 16'h0001);
    writeReg(4'd8, 16'h7FFF); writeReg(4'd9, 16'h0004);
    applyStimulus(4'd4, 4'd5, 4'b0101, 4'd0);
    checkOutput("add_ffff.result", 32'(result), 32'hFFFE);
    checkOutput("add_ffff.psr", 32'(psr), 32'h11);
    applyStimulus(4'd6, 4'd7, 4'b0101, 4'd0);
    checkOutput("add_1.result", 32'(result), 32'h0002);
    checkOutput("add_1.psr", 32'(psr), 32'h00);
    applyStimulus(4'd8, 4'd9, 4'b0101, 4'd0);
    checkOutput("add_ovf.result", 32'(result), 32'h8003);
    checkOutput("add_ovf.psr", 32'(psr), 32'h12);

    // CMP
    applyStimulus(4'd4, 4'd6, 4'b1011, 4'd0);
    checkOutput("cmp_gt.result", 32'(result), 32'hFFFE);
    checkOutput("cmp_gt.psr", 32'(psr), 32'h14);
    applyStimulus(4'd6, 4'd4, 4'b1011, 4'd0);
    checkOutput("cmp_lt.psr", 32'(psr), 32'h01);
    applyStimulus(4'd6, 4'd7, 4'b1011, 4'd0);
    checkOutput("cmp_eq.psr", 32'(psr), 32'h08);

    // SUB signed overflow
    writeReg(4'd10, 16'h8000);
    applyStimulus(4'd10, 4'd6, 4'b1001, 4'd0);
    checkOutput("sub_ovf.result", 32'(result), 32'h7FFF);
    checkOutput("sub_ovf.psr", 32'(psr), 32'h06);

    // No write-to-read bypass
    applyStimulus(4'd1, 4'd2, 4'b0001, 4'd0);
    regwrite = 1'b1; wa = 4'd1; wd = 16'h1234;
    #1;
    checkOutput("nobypass.before", 32'(rd1), 32'h0F0F);
    @(posedge clk);
    #1;
    regwrite = 1'b0;
    model[1] = 16'h1234;
    checkOutput("nobypass.after", 32'(rd1), 32'h1234);

    // Unknown opcode passes B through with clear flags
    applyStimulus(4'd1, 4'd2, 4'b0111, 4'd0);
    checkOutput("pass.result", 32'(result), 32'h5FBD);
    checkOutput("pass.psr", 32'(psr), 32'h00);

    // Random traffic against the reference model
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        d = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
        writeReg(4'($urandom_range(0, 15)), d);
      end
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)));
      checkModel("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
